// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding and defaults.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

  localparam int OSR_DEF       = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam int MID           = OSR_DEF / 2;

  function automatic int mid_of(input int osr);
    return osr / 2;
  endfunction

endpackage

// File: rtl/uart_in_sync.sv
// Two-flop synchronizer for the serial line plus a 3-sample majority voter.
module uart_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_data,
  input  logic samp_a,
  input  logic samp_b,
  output logic s,
  output logic vote
);

  logic meta;
  logic va;
  logic vb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      s    <= 1'b1;
      va   <= 1'b1;
      vb   <= 1'b1;
    end else begin
      meta <= rx_data;
      s    <= meta;
      if (samp_a) va <= s;
      if (samp_b) vb <= s;
    end
  end

  // Third sample is the live synchronized value at the deciding tick.
  assign vote = (va & vb) | (va & s) | (vb & s);

endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop,
// mid-bit majority vote, false-start rejection and framing-error flag.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OSR       = OSR_DEF
) (
  input  logic                 clk,
  input  logic                 rx_rst,
  input  logic                 rx_en,
  input  logic                 os_tick,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] Received,
  output logic                 rx_Done,
  output logic                 rx_Busy,
  output logic                 Error
);

  // state | meaning
  // IDLE  | waiting for an armed falling edge on the line
  // START | validating the start bit at mid-bit
  // DATA  | sampling DATA_BITS payload bits, LSB first
  // STOP  | sampling the stop bit, then back to IDLE at mid-stop

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_A    = TW'(mid_of(OSR) - 1);
  localparam logic [TW-1:0] T_B    = TW'(mid_of(OSR));
  localparam logic [TW-1:0] T_C    = TW'(mid_of(OSR) + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t              state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   armed;
  logic                   s;
  logic                   vote;
  logic                   samp_a;
  logic                   samp_b;

  assign samp_a = os_tick && (state != IDLE) && (tick_cnt == T_A);
  assign samp_b = os_tick && (state != IDLE) && (tick_cnt == T_B);

  uart_in_sync u_in_sync (
    .clk    (clk),
    .rst    (rx_rst),
    .rx_data(rx_data),
    .samp_a (samp_a),
    .samp_b (samp_b),
    .s      (s),
    .vote   (vote)
  );

  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      Received <= '0;
      rx_Done  <= 1'b0;
      Error    <= 1'b0;
      rx_Busy  <= 1'b0;
      armed    <= 1'b1;
    end else begin
      rx_Done <= 1'b0;
      Error   <= 1'b0;
      if (!rx_en && state != IDLE) begin
        // Abort takes priority over any coincident os_tick.
        state    <= IDLE;
        rx_Busy  <= 1'b0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        armed    <= 1'b0;
      end else if (os_tick) begin
        if (state != IDLE)
          tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
        case (state)
          IDLE: begin
            if (s) begin
              armed <= 1'b1;
            end else if (rx_en && armed) begin
              state    <= START;
              rx_Busy  <= 1'b1;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == T_C && vote) begin
              state    <= IDLE;
              rx_Busy  <= 1'b0;
              tick_cnt <= '0;
            end else if (tick_cnt == T_LAST) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (tick_cnt == T_C)
              shift <= {vote, shift[DATA_BITS-1:1]};
            if (tick_cnt == T_LAST) begin
              if (bit_cnt == B_LAST) state <= STOP;
              else                   bit_cnt <= bit_cnt + BW'(1);
            end
          end
          STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (tick_cnt == T_C) begin
              Received <= shift;
              rx_Done  <= 1'b1;
              Error    <= ~vote;
              state    <= IDLE;
              rx_Busy  <= 1'b0;
              tick_cnt <= '0;
              armed    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
